// File: rtl/alu_issue_seq_if.sv
// Bus bundle for alu_issue_seq: command intake, downstream ALU drive and result hand-off.
// The DUT uses the slave modport; the surrounding environment uses master.
interface alu_issue_seq_if #(
    parameter int WIDTH = 16
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [3:0]       CMD_FUN;
    logic [WIDTH-1:0] CMD_A;
    logic [WIDTH-1:0] CMD_B;

    logic [3:0]       ALU_FUN;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_OUT;

    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES_DATA;
    logic [1:0]       RES_CLASS;
    logic             RES_ERR;

    modport slave (
        input  CMD_VALID, CMD_FUN, CMD_A, CMD_B, ALU_OUT, RES_READY,
        output CMD_READY, ALU_FUN, ALU_A, ALU_B, RES_VALID, RES_DATA, RES_CLASS, RES_ERR
    );

    modport master (
        output CMD_VALID, CMD_FUN, CMD_A, CMD_B, ALU_OUT, RES_READY,
        input  CMD_READY, ALU_FUN, ALU_A, ALU_B, RES_VALID, RES_DATA, RES_CLASS, RES_ERR
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Command FIFO feeding an external registered ALU one command at a time, holding each result for a consumer.
// Optional macro ALU_ISSUE_SEQ_DIV0_CHECK_EN turns divide-by-zero (0011, B==0) into an error marker.
module alu_issue_seq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input logic CLK,
    input logic RST,
    alu_issue_seq_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t state, state_n;

    logic [3:0]       fifo_fun [DEPTH];
    logic [WIDTH-1:0] fifo_a   [DEPTH];
    logic [WIDTH-1:0] fifo_b   [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic             full, empty, push, pop;
    logic [3:0]       head_fun;
    logic [WIDTH-1:0] head_a, head_b;
    logic             head_err;
    logic [WIDTH-1:0] err_data;
    logic             err_pend;
    logic [WIDTH-1:0] err_data_q;

    function automatic logic [1:0] fun_class(input logic [3:0] f);
        if (f <= 4'd3)       return 2'b00;
        else if (f <= 4'd9)  return 2'b01;
        else if (f <= 4'd12) return 2'b10;
        else                 return 2'b11;
    endfunction

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.CMD_READY = !full;
    assign push          = bus.CMD_VALID && !full;
    assign head_fun      = fifo_fun[rd_ptr];
    assign head_a        = fifo_a[rd_ptr];
    assign head_b        = fifo_b[rd_ptr];

    always_comb begin
        head_err = (head_fun == 4'b1111);
        err_data = '0;
`ifdef ALU_ISSUE_SEQ_DIV0_CHECK_EN
        if (head_fun == 4'b0011 && head_b == '0) begin
            head_err = 1'b1;
            err_data = '1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    // Error markers skip ISSUE but still pass through WAIT, giving them a two-edge latency.
    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        bus.RES_VALID = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = head_err ? WAIT : ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT:  state_n = HOLD;
            HOLD: begin
                bus.RES_VALID = 1'b1;
                if (bus.RES_READY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_fun[wr_ptr] <= bus.CMD_FUN;
            fifo_a[wr_ptr]   <= bus.CMD_A;
            fifo_b[wr_ptr]   <= bus.CMD_B;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.ALU_FUN   <= 4'b1111;
            bus.ALU_A     <= '0;
            bus.ALU_B     <= '0;
            bus.RES_DATA  <= '0;
            bus.RES_CLASS <= 2'b00;
            bus.RES_ERR   <= 1'b0;
            err_pend      <= 1'b0;
            err_data_q    <= '0;
        end else begin
            if (pop) begin
                err_pend <= head_err;
                if (head_err) begin
                    err_data_q <= err_data;
                end else begin
                    bus.ALU_FUN <= head_fun;
                    bus.ALU_A   <= head_a;
                    bus.ALU_B   <= head_b;
                end
            end
            if (state == WAIT) begin
                if (err_pend) begin
                    bus.RES_DATA  <= err_data_q;
                    bus.RES_CLASS <= 2'b00;
                    bus.RES_ERR   <= 1'b1;
                end else begin
                    bus.RES_DATA  <= bus.ALU_OUT;
                    bus.RES_CLASS <= fun_class(bus.ALU_FUN);
                    bus.RES_ERR   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with a behavioural ALU and a result scoreboard.
// Honours ALU_ISSUE_SEQ_DIV0_CHECK_EN the same way as the design build.
module tb_alu_issue_seq;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  cls;
        logic        err;
        logic [3:0]  fun;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] last_fun = 4'hF;

    alu_issue_seq_if #(.WIDTH(16)) bus ();

    alu_issue_seq #(.DEPTH(4), .WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (b == 16'd0) ? 16'h0BAD : a / b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return ~a;
            4'd8:  return ~(a & b);
            4'd9:  return ~(a | b);
            4'd10: return (a == b) ? 16'd1 : 16'd0;
            4'd11: return {14'd0, a > b, a < b};
            4'd12: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd13: return a >> b[3:0];
            4'd14: return {a[14:0], 1'b0};
            default: return 16'h5A5A;
        endcase
    endfunction

    // The downstream ALU: registers its result one edge after seeing its inputs.
    always @(posedge CLK) bus.ALU_OUT <= alu_f(bus.ALU_FUN, bus.ALU_A, bus.ALU_B);

    function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        exp_t m;
        m.fun = f;
        if (f == 4'hF) begin
            m.data = 16'h0000; m.cls = 2'b00; m.err = 1'b1;
        end
`ifdef ALU_ISSUE_SEQ_DIV0_CHECK_EN
        else if (f == 4'h3 && b == 16'h0) begin
            m.data = 16'hFFFF; m.cls = 2'b00; m.err = 1'b1;
        end
`endif
        else begin
            m.data = alu_f(f, a, b);
            m.err  = 1'b0;
            if (f < 4)       m.cls = 2'b00;
            else if (f < 10) m.cls = 2'b01;
            else if (f < 13) m.cls = 2'b10;
            else             m.cls = 2'b11;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_one(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        bus.CMD_VALID = 1'b1;
        bus.CMD_FUN   = f;
        bus.CMD_A     = a;
        bus.CMD_B     = b;
        n_checks++;
        if (bus.CMD_READY !== 1'b1) $display("FAIL push_ready: got %b want 1", bus.CMD_READY);
        else begin
            n_pass++;
            exp_q.push_back(model(f, a, b));
        end
        step();
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int edges);
        edges = 0;
        while (bus.RES_VALID !== 1'b1 && edges < bound) begin
            step();
            edges++;
        end
        n_checks++;
        if (bus.RES_VALID !== 1'b1) $display("FAIL wait_valid: no RES_VALID within %0d edges", bound);
        else n_pass++;
    endtask

    task automatic accept_check(input string name);
        exp_t x;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard: result present, none expected", name);
        end else begin
            n_pass++;
            x = exp_q.pop_front();
            n_checks++;
            if (bus.RES_DATA !== x.data) $display("FAIL %s_data: got %h want %h", name, bus.RES_DATA, x.data);
            else n_pass++;
            n_checks++;
            if (bus.RES_CLASS !== x.cls) $display("FAIL %s_class: got %b want %b", name, bus.RES_CLASS, x.cls);
            else n_pass++;
            n_checks++;
            if (bus.RES_ERR !== x.err) $display("FAIL %s_err: got %b want %b", name, bus.RES_ERR, x.err);
            else n_pass++;
            if (!x.err) last_fun = x.fun;
        end
        bus.RES_READY = 1'b1;
        step();
        bus.RES_READY = 1'b0;
        n_checks++;
        if (bus.RES_VALID !== 1'b0) $display("FAIL %s_after_accept: RES_VALID got %b want 0", name, bus.RES_VALID);
        else n_pass++;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({bus.CMD_READY, bus.RES_VALID, bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR} !== {1'b1, 1'b0, 16'h0, 2'b00, 1'b0})
            $display("FAIL reset_res: got rdy=%b vld=%b data=%h cls=%b err=%b want 1 0 0000 00 0",
                     bus.CMD_READY, bus.RES_VALID, bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR);
        else n_pass++;
        n_checks++;
        if ({bus.ALU_FUN, bus.ALU_A, bus.ALU_B} !== {4'hF, 16'h0, 16'h0})
            $display("FAIL reset_alu: got fun=%h a=%h b=%h want f 0000 0000", bus.ALU_FUN, bus.ALU_A, bus.ALU_B);
        else n_pass++;
        RST = 1'b1;
        step();
    endtask

    task automatic test_latency(input string name, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int e;
        int want;
        push_one(f, a, b);
        want = (exp_q.size() != 0 && exp_q[0].err) ? 2 : 3;
        wait_valid(10, e);
        n_checks++;
        if (e != want) $display("FAIL %s_latency: got %0d edges want %0d", name, e, want);
        else n_pass++;
        if (f == 4'hF) begin
            n_checks++;
            if (bus.ALU_FUN !== last_fun) $display("FAIL %s_alu_fun: got %h want %h", name, bus.ALU_FUN, last_fun);
            else n_pass++;
        end
        accept_check(name);
    endtask

    task automatic test_compare_shift();
        int e;
        push_one(4'b1011, 16'd9, 16'd4);
        push_one(4'b1110, 16'h8001, 16'h0000);
        wait_valid(10, e);
        accept_check("cmp");
        wait_valid(10, e);
        accept_check("shift");
    endtask

    task automatic test_back_to_back();
        int e;
        bus.RES_READY = 1'b0;
        for (int i = 0; i < 5; i++) push_one(4'(i + 4), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.CMD_READY !== 1'b0) $display("FAIL full_ready: cycle %0d got %b want 0", i, bus.CMD_READY);
            else n_pass++;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            wait_valid(10, e);
            accept_check("order");
            if (i == 0) begin
                step();
                n_checks++;
                if (bus.CMD_READY !== 1'b1) $display("FAIL ready_after_pop: got %b want 1", bus.CMD_READY);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        bus.RES_READY = 1'b0;
        push_one(4'd0, 16'd1, 16'd2);
        push_one(4'd1, 16'd9, 16'd3);
        push_one(4'd5, 16'h00F0, 16'h0F00);
        RST = 1'b0;
        #1;
        exp_q.delete();
        last_fun = 4'hF;
        n_checks++;
        if ({bus.CMD_READY, bus.RES_VALID, bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR,
             bus.ALU_FUN, bus.ALU_A, bus.ALU_B} !== {1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 4'hF, 16'h0, 16'h0})
            $display("FAIL midop_reset: got rdy=%b vld=%b data=%h cls=%b err=%b fun=%h a=%h b=%h",
                     bus.CMD_READY, bus.RES_VALID, bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR,
                     bus.ALU_FUN, bus.ALU_A, bus.ALU_B);
        else n_pass++;
        step();
        step();
        RST = 1'b1;
        bus.RES_READY = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.RES_VALID === 1'b1) seen++;
            step();
        end
        bus.RES_READY = 1'b0;
        n_checks++;
        if (seen != 0) $display("FAIL midop_ghost: got %0d result cycles want 0", seen);
        else n_pass++;
        test_latency("post_reset", 4'd2, 16'd6, 16'd7);
    endtask

    task automatic test_random();
        localparam int N = 24;
        int got = 0;
        fork
            begin
                logic [3:0]  f;
                logic [15:0] a, b;
                int guard;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    f = 4'($urandom_range(0, 15));
                    a = 16'($urandom);
                    b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    bus.CMD_VALID = 1'b1;
                    bus.CMD_FUN   = f;
                    bus.CMD_A     = a;
                    bus.CMD_B     = b;
                    guard = 0;
                    while (bus.CMD_READY !== 1'b1 && guard < 300) begin
                        step();
                        guard++;
                    end
                    if (bus.CMD_READY !== 1'b1) begin
                        n_checks++;
                        $display("FAIL rand_push_timeout: CMD_READY stuck at %b", bus.CMD_READY);
                        break;
                    end
                    exp_q.push_back(model(f, a, b));
                    step();
                    bus.CMD_VALID = 1'b0;
                end
            end
            begin
                exp_t x;
                int cyc = 0;
                while (got < N && cyc < 3000) begin
                    bus.RES_READY = 1'($urandom_range(0, 1));
                    if (bus.RES_VALID === 1'b1 && bus.RES_READY) begin
                        n_checks++;
                        if (exp_q.size() == 0) $display("FAIL rand_scoreboard: unexpected result %h", bus.RES_DATA);
                        else begin
                            n_pass++;
                            x = exp_q.pop_front();
                            n_checks++;
                            if ({bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR} !== {x.data, x.cls, x.err})
                                $display("FAIL rand_result: got %h/%b/%b want %h/%b/%b fun=%h",
                                         bus.RES_DATA, bus.RES_CLASS, bus.RES_ERR, x.data, x.cls, x.err, x.fun);
                            else n_pass++;
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                bus.RES_READY = 1'b0;
            end
        join
        n_checks++;
        if (got != N) $display("FAIL rand_count: got %0d results want %0d", got, N);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_FUN   = 4'h0;
        bus.CMD_A     = 16'h0;
        bus.CMD_B     = 16'h0;
        bus.RES_READY = 1'b0;
        test_reset();
        test_latency("add", 4'b0000, 16'd3, 16'd5);
        test_compare_shift();
        test_latency("err_op", 4'b1111, 16'd1, 16'd1);
        test_latency("div0", 4'b0011, 16'd7, 16'd0);
        test_latency("div", 4'b0011, 16'd21, 16'd4);
        test_back_to_back();
        test_reset_midop();
        test_random();
        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
